// File: rtl/dx_stage_buffer.sv
// Decode->execute stage buffer: two-entry skid buffer with valid/ready on both sides,
// flush-to-bubble, NOP on empty output slot and a saturating back-pressure counter.
module dx_stage_buffer #(
  parameter int                DATA_W    = 32,
  parameter int                CTRL_W    = 10,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_PC_next,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_immediate,
  input  logic [DATA_W-1:0] in_data_readRegA,
  input  logic [DATA_W-1:0] in_data_readRegB,
  input  logic [CTRL_W-1:0] in_ctrl_signals,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_PC_next,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_immediate,
  output logic [DATA_W-1:0] out_data_readRegA,
  output logic [DATA_W-1:0] out_data_readRegB,
  output logic [CTRL_W-1:0] out_ctrl_signals,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rega;
    logic [DATA_W-1:0] regb;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam entry_t BUBBLE = '{pc: '0, instr: NOP_INSTR, imm: '0,
                                rega: '0, regb: '0, ctrl: '0};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  entry_t           m_q, m_d;
  entry_t           s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  entry_t           in_entry;
  logic             accept;
  logic             drain;

  assign in_entry = '{pc: in_PC_next, instr: in_instr, imm: in_immediate,
                      rega: in_data_readRegA, regb: in_data_readRegB,
                      ctrl: in_ctrl_signals};

  // Handshake flags decode only the registered state, never the peer's inputs.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = BUBBLE;
      s_d     = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            m_d     = in_entry;
          end
        end
        ONE: begin
          if (accept && drain) begin
            m_d = in_entry;
          end else if (accept) begin
            state_d = FULL;
            s_d     = in_entry;
          end else if (drain) begin
            state_d = EMPTY;
            m_d     = BUBBLE;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            m_d     = s_q;
            s_d     = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = BUBBLE;
          s_d     = BUBBLE;
        end
      endcase
    end
  end

  // Counts stalled cycles even across a flush; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !out_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      m_q     <= BUBBLE;
      s_q     <= BUBBLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_PC_next       = m_q.pc;
  assign out_instr         = m_q.instr;
  assign out_immediate     = m_q.imm;
  assign out_data_readRegA = m_q.rega;
  assign out_data_readRegB = m_q.regb;
  assign out_ctrl_signals  = m_q.ctrl;
  assign stall_count       = cnt_q;

endmodule

// File: tb/tb_dx_stage_buffer.sv
// Randomized plus directed bench for dx_stage_buffer, checked against a queue-based
// reference model of a two-deep FIFO with flush and a saturating stall counter.
module tb_dx_stage_buffer;

  localparam int          DATA_W = 32;
  localparam int          CTRL_W = 10;
  localparam int          CNT_W  = 4;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clock = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_PC_next, in_instr, in_immediate, in_data_readRegA, in_data_readRegB;
  logic [CTRL_W-1:0] in_ctrl_signals;
  logic [DATA_W-1:0] out_PC_next, out_instr, out_immediate, out_data_readRegA, out_data_readRegB;
  logic [CTRL_W-1:0] out_ctrl_signals;
  logic [CNT_W-1:0]  stall_count;

  always #5 clock = ~clock;

  dx_stage_buffer #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_PC_next(in_PC_next), .in_instr(in_instr), .in_immediate(in_immediate),
    .in_data_readRegA(in_data_readRegA), .in_data_readRegB(in_data_readRegB),
    .in_ctrl_signals(in_ctrl_signals),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_PC_next(out_PC_next), .out_instr(out_instr), .out_immediate(out_immediate),
    .out_data_readRegA(out_data_readRegA), .out_data_readRegB(out_data_readRegB),
    .out_ctrl_signals(out_ctrl_signals), .stall_count(stall_count)
  );

  typedef struct {
    logic [31:0] pc, instr, imm, a, b;
    logic [9:0]  ctrl;
  } item_t;

  item_t mq[$];
  int    m_cnt;
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL cyc=%0d %s got=%h expected=%h", cyc, tag, got, exp);
    end
  endtask

  function automatic item_t rnd_item(input logic [31:0] instr);
    item_t it;
    it.pc    = $urandom;
    it.instr = instr;
    it.imm   = $urandom;
    it.a     = $urandom;
    it.b     = $urandom;
    it.ctrl  = 10'($urandom);
    return it;
  endfunction

  task automatic compare_outputs();
    item_t h;
    bit    v;
    v = (mq.size() > 0);
    if (v) h = mq[0];
    else   h = '{pc: 0, instr: NOP, imm: 0, a: 0, b: 0, ctrl: 0};
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    chk("out_instr", out_instr, h.instr);
    chk("out_ctrl", 32'(out_ctrl_signals), 32'(h.ctrl));
    chk("out_pc", out_PC_next, h.pc);
    chk("out_imm", out_immediate, h.imm);
    chk("out_regA", out_data_readRegA, h.a);
    chk("out_regB", out_data_readRegB, h.b);
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
  endtask

  // Called at a negedge: check current outputs, drive inputs, advance the model.
  task automatic cycle(input bit rst, input bit fl, input bit iv, input bit ordy,
                       input item_t it, input bit do_check);
    bit can_acc, can_drn;
    if (do_check) compare_outputs();
    $display("cyc=%0d rst=%0b fl=%0b iv=%0b instr=%h ordy=%0b | ov=%0b ir=%0b out_instr=%h cnt=%0d",
             cyc, rst, fl, iv, it.instr, ordy, out_valid, in_ready, out_instr, stall_count);
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy;
    in_PC_next = it.pc; in_instr = it.instr; in_immediate = it.imm;
    in_data_readRegA = it.a; in_data_readRegB = it.b; in_ctrl_signals = it.ctrl;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
    end else begin
      if (mq.size() > 0 && !ordy && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (fl) begin
        mq.delete();
      end else begin
        can_drn = (mq.size() > 0) && ordy;
        can_acc = iv && (mq.size() < 2);
        if (can_drn) void'(mq.pop_front());
        if (can_acc) mq.push_back(it);
      end
    end
    @(negedge clock);
    cyc++;
  endtask

  initial begin
    item_t it;
    it = rnd_item(32'h0);
    @(negedge clock);
    // Reset then idle
    cycle(1, 0, 0, 0, it, 0);
    cycle(1, 0, 0, 0, it, 0);
    cycle(0, 0, 0, 0, it, 1);
    cycle(0, 0, 0, 1, it, 1);

    // Streaming
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 1, rnd_item(32'h11 + 32'(i)), 1);
    cycle(0, 0, 0, 1, it, 1);
    cycle(0, 0, 0, 1, it, 1);

    // Back-pressure / skid: A3 held upstream while FULL
    cycle(0, 0, 1, 0, rnd_item(32'hA1), 1);
    cycle(0, 0, 1, 0, rnd_item(32'hA2), 1);
    it = rnd_item(32'hA3);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, it, 1);
    cycle(0, 0, 1, 1, it, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, it, 1);

    // Flush while FULL with accept/drain offered in the same cycle
    cycle(0, 0, 1, 0, rnd_item(32'hB1), 1);
    cycle(0, 0, 1, 0, rnd_item(32'hB2), 1);
    cycle(0, 1, 1, 1, rnd_item(32'hB3), 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, it, 1);

    // Counter saturation, flush keeps the count, reset clears it
    cycle(0, 0, 1, 0, rnd_item(32'hC1), 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, it, 1);
    cycle(0, 1, 0, 0, it, 1);
    cycle(0, 0, 0, 0, it, 1);
    cycle(1, 0, 0, 0, it, 1);
    cycle(0, 0, 0, 0, it, 1);

    // Reset mid-stream while FULL with out_ready = 1
    cycle(0, 0, 1, 0, rnd_item(32'hD1), 1);
    cycle(0, 0, 1, 0, rnd_item(32'hD2), 1);
    cycle(1, 0, 1, 1, rnd_item(32'hD3), 1);
    cycle(0, 0, 0, 0, it, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            rnd_item($urandom), 1);
    end
    compare_outputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
